// File: rtl/reg_file_pkg.sv
// Shared reg_file constants: data width (from the REG_WIDTH define), register count,
// index width and the clear-FSM state encoding pair.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

package reg_file_pkg;
    localparam int REG_W     = `REG_WIDTH;
    localparam int REG_COUNT = 32;
    localparam int IDX_W     = 5;

    localparam logic ST_CLEAR_ENC = 1'b0;
    localparam logic ST_READY_ENC = 1'b1;

    typedef enum logic {
        ST_CLEAR = ST_CLEAR_ENC,
        ST_READY = ST_READY_ENC
    } rf_state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_COUNT - 1);
endpackage

// File: rtl/reg_file_clear_fsm.sv
// Post-reset clear sweep: walks the index 0..31 one entry per cycle, then parks in READY.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int RESET_CLEAR = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_state,
    output logic [IDX_W-1:0] o_index,
    output logic             o_busy
);

    rf_state_e        r_state;
    rf_state_e        w_state_nxt;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] w_index_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= (RESET_CLEAR != 0) ? ST_CLEAR : ST_READY;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        case (r_state)
            ST_CLEAR: begin
                w_index_nxt = IDX_W'(r_index + 1'b1);
                // Leaving on the edge that clears the last entry keeps the sweep at exactly 32 cycles.
                if (r_index == LAST_IDX) begin
                    w_state_nxt = ST_READY;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    assign o_state = r_state;
    assign o_index = r_index;
    assign o_busy  = (r_state == ST_CLEAR);

endmodule

// File: rtl/reg_file.sv
// 32-entry register file with two bypassed read ports and a post-reset clear sweep.
// Optional registered debug read port enabled by defining REGFILE_DBG_PORT_EN.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module reg_file
    import reg_file_pkg::*;
#(
    parameter int RESET_CLEAR = 1
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_sys_i,
    input  logic [IDX_W-1:0]      wb_rd_i,
    input  logic                  wb_wen_i,
    input  logic [`REG_WIDTH-1:0] wb_data_i,
    input  logic [IDX_W-1:0]      rs1_addr_i,
    input  logic [IDX_W-1:0]      rs2_addr_i,
    output logic [`REG_WIDTH-1:0] rs1_data_o,
    output logic [`REG_WIDTH-1:0] rs2_data_o,
    output logic                  busy_o
`ifdef REGFILE_DBG_PORT_EN
    ,
    input  logic [IDX_W-1:0]      dbg_addr_i,
    output logic [`REG_WIDTH-1:0] dbg_data_o
`endif
);

    logic [REG_W-1:0] r_regs [REG_COUNT];

    logic             w_state;
    logic [IDX_W-1:0] w_clr_idx;
    logic             w_busy;
    logic             w_wb_en;
    logic [REG_W-1:0] w_rs1_data;
    logic [REG_W-1:0] w_rs2_data;

    reg_file_clear_fsm #(
        .RESET_CLEAR (RESET_CLEAR)
    ) u_clear_fsm (
        .i_clk   (clk_sys_i),
        .i_rst   (rst_sys_i),
        .o_state (w_state),
        .o_index (w_clr_idx),
        .o_busy  (w_busy)
    );

    // A write-back landing in a reset cycle is dropped, so it must not bypass either.
    assign w_wb_en = !rst_sys_i && (w_state == ST_READY_ENC) && wb_wen_i && (wb_rd_i != '0);

    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_i) begin
            if (w_busy) begin
                r_regs[w_clr_idx] <= '0;
            end else if (w_wb_en) begin
                r_regs[wb_rd_i] <= wb_data_i;
            end
        end
    end

    always_comb begin
        w_rs1_data = r_regs[rs1_addr_i];
        if (w_busy || (rs1_addr_i == '0)) begin
            w_rs1_data = '0;
        end else if (w_wb_en && (wb_rd_i == rs1_addr_i)) begin
            w_rs1_data = wb_data_i;
        end
    end

    always_comb begin
        w_rs2_data = r_regs[rs2_addr_i];
        if (w_busy || (rs2_addr_i == '0)) begin
            w_rs2_data = '0;
        end else if (w_wb_en && (wb_rd_i == rs2_addr_i)) begin
            w_rs2_data = wb_data_i;
        end
    end

    assign rs1_data_o = w_rs1_data;
    assign rs2_data_o = w_rs2_data;
    assign busy_o     = w_busy;

`ifdef REGFILE_DBG_PORT_EN
    logic [REG_W-1:0] r_dbg_data;

    // Reads the array before this edge's write lands, so a same-cycle write shows the old value.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_dbg_data <= '0;
        end else if (dbg_addr_i == '0) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= r_regs[dbg_addr_i];
        end
    end

    assign dbg_data_o = r_dbg_data;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: clear sweep, bypass, x0 handling, restart and reset-without-clear.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module tb_reg_file;
    localparam int W = `REG_WIDTH;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with the default clear sweep
    logic         rst;
    logic         wen;
    logic [4:0]   rd;
    logic [W-1:0] wdata;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [W-1:0] rs1_data;
    logic [W-1:0] rs2_data;
    logic         busy;

    // Instance built with RESET_CLEAR=0
    logic         nc_rst;
    logic         nc_wen;
    logic [4:0]   nc_rd;
    logic [W-1:0] nc_wdata;
    logic [4:0]   nc_rs1;
    logic [4:0]   nc_rs2;
    logic [W-1:0] nc_rs1_data;
    logic [W-1:0] nc_rs2_data;
    logic         nc_busy;

`ifdef REGFILE_DBG_PORT_EN
    logic [4:0]   dbg_addr;
    logic [W-1:0] dbg_data;
    logic [4:0]   nc_dbg_addr;
    logic [W-1:0] nc_dbg_data;
`endif

    reg_file #(.RESET_CLEAR(1)) dut (
        .clk_sys_i  (clk),
        .rst_sys_i  (rst),
        .wb_rd_i    (rd),
        .wb_wen_i   (wen),
        .wb_data_i  (wdata),
        .rs1_addr_i (rs1),
        .rs2_addr_i (rs2),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .busy_o     (busy)
`ifdef REGFILE_DBG_PORT_EN
        ,
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
`endif
    );

    reg_file #(.RESET_CLEAR(0)) dut_nc (
        .clk_sys_i  (clk),
        .rst_sys_i  (nc_rst),
        .wb_rd_i    (nc_rd),
        .wb_wen_i   (nc_wen),
        .wb_data_i  (nc_wdata),
        .rs1_addr_i (nc_rs1),
        .rs2_addr_i (nc_rs2),
        .rs1_data_o (nc_rs1_data),
        .rs2_data_o (nc_rs2_data),
        .busy_o     (nc_busy)
`ifdef REGFILE_DBG_PORT_EN
        ,
        .dbg_addr_i (nc_dbg_addr),
        .dbg_data_o (nc_dbg_data)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts negedges with busy high; entered just after reset release.
    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(name, W'(n), W'(32));
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 64) begin
            n++;
            @(negedge clk);
        end
        check(name, W'(busy), W'(0));
    endtask

    typedef struct {
        logic         wen;
        logic [4:0]   rd;
        logic [W-1:0] wdata;
        logic [4:0]   a1;
        logic [4:0]   a2;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Applied from a cleared array; expectations include same-cycle bypass.
        vecs[0]  = '{1'b1, 5'd5,  W'(32'hDEADBEEF), 5'd5,  5'd0,  W'(32'hDEADBEEF), W'(0)};
        vecs[1]  = '{1'b0, 5'd5,  W'(32'h0BADF00D), 5'd5,  5'd5,  W'(32'hDEADBEEF), W'(32'hDEADBEEF)};
        vecs[2]  = '{1'b1, 5'd0,  W'(32'h0000FFFF), 5'd0,  5'd0,  W'(0),            W'(0)};
        vecs[3]  = '{1'b0, 5'd0,  W'(0),            5'd0,  5'd0,  W'(0),            W'(0)};
        vecs[4]  = '{1'b1, 5'd7,  W'(32'h11),       5'd7,  5'd7,  W'(32'h11),       W'(32'h11)};
        vecs[5]  = '{1'b1, 5'd8,  W'(32'h22),       5'd7,  5'd8,  W'(32'h11),       W'(32'h22)};
        vecs[6]  = '{1'b0, 5'd8,  W'(32'h99),       5'd8,  5'd8,  W'(32'h22),       W'(32'h22)};
        vecs[7]  = '{1'b1, 5'd31, W'(32'hA5A5A5A5), 5'd31, 5'd1,  W'(32'hA5A5A5A5), W'(0)};
        vecs[8]  = '{1'b0, 5'd3,  W'(32'h77),       5'd31, 5'd5,  W'(32'hA5A5A5A5), W'(32'hDEADBEEF)};
        vecs[9]  = '{1'b1, 5'd5,  W'(32'h12345678), 5'd5,  5'd3,  W'(32'h12345678), W'(0)};
        vecs[10] = '{1'b0, 5'd5,  W'(0),            5'd5,  5'd30, W'(32'h12345678), W'(0)};

        rst = 1'b1; wen = 1'b0; rd = '0; wdata = '0; rs1 = 5'd5; rs2 = 5'd9;
        nc_rst = 1'b1; nc_wen = 1'b0; nc_rd = '0; nc_wdata = '0; nc_rs1 = '0; nc_rs2 = '0;
`ifdef REGFILE_DBG_PORT_EN
        dbg_addr = '0;
        nc_dbg_addr = '0;
`endif

        // Reset state
        @(negedge clk);
        check("reset_busy", W'(busy), W'(1));
        check("reset_rs1_zero", rs1_data, W'(0));
        check("reset_rs2_zero", rs2_data, W'(0));
        check("nc_reset_busy", W'(nc_busy), W'(0));
`ifdef REGFILE_DBG_PORT_EN
        check("reset_dbg_zero", dbg_data, W'(0));
`endif
        rst = 1'b0;
        nc_rst = 1'b0;
        #1;
        count_busy("sweep_busy_len");

        for (int i = 1; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(32 - i);
            #1;
            check($sformatf("swept_rs1_x%0d", i), rs1_data, W'(0));
            check($sformatf("swept_rs2_x%0d", 32 - i), rs2_data, W'(0));
            @(negedge clk);
        end

        for (int i = 0; i < NVEC; i++) begin
            wen = vecs[i].wen; rd = vecs[i].rd; wdata = vecs[i].wdata;
            rs1 = vecs[i].a1;  rs2 = vecs[i].a2;
            #1;
            check($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].e1);
            check($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].e2);
            @(negedge clk);
        end
        wen = 1'b0;

        // Write during clear cycle 10 is dropped
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        wen = 1'b1; rd = 5'd3; wdata = W'(7); rs1 = 5'd3; rs2 = 5'd5;
        #1;
        check("clr10_busy", W'(busy), W'(1));
        check("clr10_rs1_zero", rs1_data, W'(0));
        check("clr10_rs2_zero", rs2_data, W'(0));
        @(negedge clk);
        wen = 1'b0;
        wait_ready("clr10_ready");
        rs1 = 5'd3; rs2 = 5'd5;
        #1;
        check("clr10_x3_dropped", rs1_data, W'(0));
        check("clr10_x5_cleared", rs2_data, W'(0));
        @(negedge clk);

        // Reset at clear cycle 20 restarts a full 32-cycle sweep
        wen = 1'b1; rd = 5'd6; wdata = W'(32'hCAFE);
        @(negedge clk);
        wen = 1'b0; rs1 = 5'd6;
        #1;
        check("x6_written", rs1_data, W'(32'hCAFE));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("clr20_busy", W'(busy), W'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        count_busy("restart_busy_len");
        rs1 = 5'd6; rs2 = 5'd31;
        #1;
        check("restart_x6_cleared", rs1_data, W'(0));
        check("restart_x31_cleared", rs2_data, W'(0));
        @(negedge clk);

`ifdef REGFILE_DBG_PORT_EN
        wen = 1'b1; rd = 5'd9; wdata = W'(32'h55); dbg_addr = 5'd0;
        @(negedge clk);
        wen = 1'b0; dbg_addr = 5'd9;
        @(negedge clk);
        check("dbg_x9", dbg_data, W'(32'h55));
        wen = 1'b1; rd = 5'd9; wdata = W'(32'h66);
        @(negedge clk);
        wen = 1'b0;
        check("dbg_x9_old", dbg_data, W'(32'h55));
        @(negedge clk);
        check("dbg_x9_new", dbg_data, W'(32'h66));
        dbg_addr = 5'd0;
        @(negedge clk);
        check("dbg_x0", dbg_data, W'(0));
        dbg_addr = 5'd9;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("dbg_after_reset", dbg_data, W'(0));
`endif

        // RESET_CLEAR=0: reset keeps contents, write in reset cycle is dropped
        nc_wen = 1'b1; nc_rd = 5'd4; nc_wdata = W'(32'h1234); nc_rs1 = 5'd4; nc_rs2 = 5'd0;
        #1;
        check("nc_bypass_x4", nc_rs1_data, W'(32'h1234));
        @(negedge clk);
        nc_rst = 1'b1; nc_wdata = W'(32'h9999);
        @(negedge clk);
        nc_rst = 1'b0; nc_wen = 1'b0; nc_rs1 = 5'd4; nc_rs2 = 5'd4;
        #1;
        check("nc_busy_after_reset", W'(nc_busy), W'(0));
        check("nc_x4_kept_rs1", nc_rs1_data, W'(32'h1234));
        check("nc_x4_kept_rs2", nc_rs2_data, W'(32'h1234));
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter RESET_CLEAR, default 1; 1 = zero all registers after reset, 0 = skip the clear sweep.
REQ-002 SHALL have port clk_sys_i  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_sys_i  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port wb_rd_i  input  5  write-back destination register index.
REQ-005 SHALL have port wb_wen_i  input  1  write-back write enable.
REQ-006 SHALL have port wb_data_i  input  `REG_WIDTH  write-back result.
REQ-007 SHALL have port rs1_addr_i  input  5  read port 1 index.
REQ-008 SHALL have port rs2_addr_i  input  5  read port 2 index.
REQ-009 SHALL have port rs1_data_o  output  `REG_WIDTH  read port 1 data, combinational.
REQ-010 SHALL have port rs2_data_o  output  `REG_WIDTH  read port 2 data, combinational.
REQ-011 SHALL have port busy_o  output  1  clear sweep in progress; the decode stage stalls while high.

Function
REQ-012 SHALL hold 32 entries of `REG_WIDTH bits; x0 always reads 0, and writes to x0 are discarded.
REQ-013 SHALL implement a two-state FSM: CLEAR and READY.
REQ-014 CLEAR SHALL write 0 to the entry at a 5-bit index each cycle, increment the index, and move to READY on the cycle it writes index 31.
REQ-015 The clear sweep SHALL last exactly 32 cycles, with busy_o high for all of them.
REQ-016 In READY, when wb_wen_i=1 and wb_rd_i!=0, wb_data_i SHALL be written to entry wb_rd_i at the clock edge.
REQ-017 Each read port SHALL return the array content for its index, with zero added latency.
REQ-018 Bypass: in READY, if wb_wen_i=1, wb_rd_i!=0 and wb_rd_i equals a read index, that port SHALL return wb_data_i in the same cycle.
REQ-019 Bypass SHALL apply to both read ports independently, including when both ports use the same index.
REQ-020 While busy_o=1: both read outputs SHALL be 0, and write-back writes SHALL be dropped and never replayed.
REQ-021 wb_rd_i, wb_data_i, rs1_addr_i and rs2_addr_i SHALL have no effect when wb_wen_i=0, apart from normal array reads.

Reset
REQ-022 When rst_sys_i is sampled high, the next state SHALL be CLEAR with index 0 if RESET_CLEAR=1, otherwise READY.
REQ-023 The first clock edge with rst_sys_i low after reset SHALL perform clear index 0.
REQ-024 Reset values: busy_o=1 if RESET_CLEAR=1, else 0; rs1_data_o=rs2_data_o=0 while in CLEAR.
REQ-025 Reset asserted mid-sweep SHALL restart the sweep at index 0.
REQ-026 Reset asserted in READY with RESET_CLEAR=0 SHALL leave entries 1..31 unchanged.
REQ-027 A write-back pending in the same cycle as reset SHALL be dropped.

Configuration
REQ-028 Macro REGFILE_DBG_PORT_EN defined SHALL add ports dbg_addr_i (input, 5) and dbg_data_o (output, `REG_WIDTH).
REQ-029 dbg_data_o SHALL be registered: one cycle after dbg_addr_i is presented, it holds the array content for that index, with no bypass; it is 0 for x0 and 0 after reset.
REQ-030 Without REGFILE_DBG_PORT_EN, these ports and their register SHALL be absent, with no other behavioural change.

Structure
REQ-031 `REG_WIDTH SHALL come from the shared QianTang header.
REQ-032 The register count (32) and index width (5) SHALL be defined as shared header constants.
REQ-033 The FSM state encoding SHALL be a shared header constant pair.
REQ-034 The clear sweep SHALL be a sub-module, reg_file_clear_fsm, with outputs state, index and busy; the storage array and bypass logic stay in reg_file.

Verification
REQ-035 Scenario: reset 1 cycle, RESET_CLEAR=1 -> busy_o high for exactly 32 cycles; all rs reads of x1..x31 then return 0.
REQ-036 Scenario: write x5=0xDEADBEEF with rs1_addr_i=5 in the same cycle -> rs1_data_o=0xDEADBEEF that cycle (bypass) and on the next cycle (array).
REQ-037 Scenario: wb_wen_i=1, wb_rd_i=0, data 0xFFFF, with rs1=rs2=0 -> both outputs 0; a later read of x0 returns 0.
REQ-038 Scenario: write x3=7 at clear cycle 10 -> write dropped; after READY, x3 reads 0.
REQ-039 Scenario: reset at clear cycle 20 -> busy_o stays high for a further 32 full cycles after reset release.
REQ-040 Scenario: with REGFILE_DBG_PORT_EN, write x9=0x55 and then set dbg_addr_i=9 -> dbg_data_o=0x55 one cycle later; in the same-cycle-write case it shows the old value.
